// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared definitions for the multicycle MIPS-subset control path.
//               Holds the opcode constants, the control FSM state type, and the
//               ALUOp / ALUSrcB / PCSrc select encodings. The datapath and the
//               ALU decoder import the same package.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // Opcode field values, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Control FSM states. The encoding is 4 bits wide; codes 12..15 are unused
    // and fall back to ST_FETCH.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMRD    = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWR    = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ADDIEXEC = 4'd9,
        ST_ADDIWB   = 4'd10,
        ST_JUMP     = 4'd11
    } mc_state_t;

    // ALUOp: operation requested from the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB: second ALU operand
    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    // PCSrc: next-PC source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode this control unit knows how to sequence
    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_perf_counters.sv
`default_nettype none
// ============================================================================
// Module      : mc_perf_counters
// Description : Free-running cycle counter and retired-instruction counter for
//               the multicycle control FSM. Both wrap modulo 2^CNT_W.
// Ports       : clk          - clock, rising edge
//               rst_n        - asynchronous active-low reset, clears both
//               i_instr_done - one cycle per completed instruction
//               o_cycle_cnt  - clocks since reset release
//               o_instr_cnt  - completed instructions since reset release
// Revision    : 1.0 - initial release
// ============================================================================
module mc_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_instr_done,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instr_cnt
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + c_ONE;
            if (i_instr_done) begin
                r_instr_cnt <= r_instr_cnt + c_ONE;
            end
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
    assign o_instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM of the multicycle MIPS-subset datapath.
//               Sequences fetch / decode / address / memory / execute /
//               writeback and drives every datapath select and write enable.
//               Memory accesses wait on the MemReady handshake.
// Ports       : CLK, RST (async active-low), Op (opcode from IR), MemReady
//               Memory : MemRead, MemWrite, IorD
//               Regs   : IRWrite, RegDst, MemtoReg, RegWrite
//               ALU    : ALUSrcA, ALUSrcB, ALUOp
//               PC     : PCSrc, PCWrite, Branch
//               Status : IllegalOp (one-cycle pulse in DECODE)
// Options     : PERF_CNT_EN - adds CycleCnt / InstrCnt outputs (CNT_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IllegalOp
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstrCnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("multicycle_control: CNT_W must be at least 1");
    end

    mc_state_t r_state;
    mc_state_t w_next;
    logic      w_instr_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Op is only looked at in DECODE and MEMADR;
    // MemReady only in FETCH, MEMRD and MEMWR.
    // ------------------------------------------------------------------
    always_comb begin
        w_next       = ST_FETCH;
        w_instr_done = 1'b0;
        case (r_state)
            ST_FETCH:    w_next = MemReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_RTYPE:     w_next = ST_EXECUTE;
                    OP_BEQ:       w_next = ST_BRANCH;
                    OP_ADDI:      w_next = ST_ADDIEXEC;
                    OP_J:         w_next = ST_JUMP;
                    // Unsupported opcode: abandon the instruction, not counted
                    default:      w_next = ST_FETCH;
                endcase
            end
            ST_MEMADR:   w_next = (Op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:    w_next = MemReady ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB: begin
                w_next       = ST_FETCH;
                w_instr_done = 1'b1;
            end
            ST_MEMWR: begin
                w_next       = MemReady ? ST_FETCH : ST_MEMWR;
                w_instr_done = MemReady;
            end
            ST_EXECUTE:  w_next = ST_ALUWB;
            ST_ADDIEXEC: w_next = ST_ADDIWB;
            ST_ALUWB, ST_BRANCH, ST_ADDIWB, ST_JUMP: begin
                w_next       = ST_FETCH;
                w_instr_done = 1'b1;
            end
            default:     w_next = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode of the current state (plus MemReady in FETCH and Op
    // in DECODE). Anything not set by a state stays 0.
    // ------------------------------------------------------------------
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_iord;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_src;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_illegal;

    always_comb begin
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = ALUSRCB_B;
        w_alu_op     = ALUOP_ADD;
        w_pc_src     = PCSRC_ALU;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // PC+4 is computed every fetch cycle, but IR and PC are only
                // loaded in the cycle the memory returns the instruction.
                w_mem_read  = 1'b1;
                w_alu_src_b = ALUSRCB_FOUR;
                w_ir_write  = MemReady;
                w_pc_write  = MemReady;
            end
            ST_DECODE: begin
                // Branch target precompute into ALUOut
                w_alu_src_b = ALUSRCB_IMM_SH2;
                w_illegal   = ~is_legal_op(Op);
            end
            ST_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = ALUSRCB_IMM;
            end
            ST_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            ST_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            ST_EXECUTE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_SUB;
                w_pc_src    = PCSRC_ALUOUT;
                w_branch    = 1'b1;
            end
            ST_ADDIEXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = ALUSRCB_IMM;
            end
            ST_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            ST_JUMP: begin
                w_pc_src   = PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // While reset is low the state is already FETCH, but FETCH would drive
    // MemRead, so every output is additionally gated by RST to force 0.
    assign MemRead   = RST & w_mem_read;
    assign MemWrite  = RST & w_mem_write;
    assign IorD      = RST & w_iord;
    assign IRWrite   = RST & w_ir_write;
    assign RegDst    = RST & w_reg_dst;
    assign MemtoReg  = RST & w_mem_to_reg;
    assign RegWrite  = RST & w_reg_write;
    assign ALUSrcA   = RST & w_alu_src_a;
    assign ALUSrcB   = RST ? w_alu_src_b : 2'b00;
    assign ALUOp     = RST ? w_alu_op    : 2'b00;
    assign PCSrc     = RST ? w_pc_src    : 2'b00;
    assign PCWrite   = RST & w_pc_write;
    assign Branch    = RST & w_branch;
    assign IllegalOp = RST & w_illegal;

`ifdef PERF_CNT_EN
    mc_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (CLK),
        .rst_n        (RST),
        .i_instr_done (w_instr_done),
        .o_cycle_cnt  (CycleCnt),
        .o_instr_cnt  (InstrCnt)
    );
`else
    // Completion strobe only feeds the optional counters
    logic w_instr_done_unused;
    assign w_instr_done_unused = w_instr_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Each instruction
//               is expanded into its expected cycle-by-cycle control pattern
//               from the opcode and the number of memory wait cycles, then
//               replayed against the DUT with random don't-care inputs.
// Options     : PERF_CNT_EN - also checks CycleCnt / InstrCnt
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic        CLK;
    logic        RST;
    logic [5:0]  Op;
    logic        MemReady;
    logic        MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite;
    logic        ALUSrcA, PCWrite, Branch, IllegalOp;
    logic [1:0]  ALUSrcB, ALUOp, PCSrc;
`ifdef PERF_CNT_EN
    logic [31:0] CycleCnt;
    logic [31:0] InstrCnt;
`endif

    multicycle_control #(
        .CNT_W (32)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Op        (Op),
        .MemReady  (MemReady),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .PCSrc     (PCSrc),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .IllegalOp (IllegalOp)
`ifdef PERF_CNT_EN
        ,
        .CycleCnt  (CycleCnt),
        .InstrCnt  (InstrCnt)
`endif
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    // Observed control word
    logic [16:0] w_obs;
    assign w_obs = {MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite,
                    ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, IllegalOp};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected control word from named fields
    function automatic logic [16:0] ov(input logic mr, input logic mw, input logic iord,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] pcs,
                                       input logic pcw, input logic br, input logic ill);
        return {mr, mw, iord, irw, rd, m2r, rw, asa, asb, aop, pcs, pcw, br, ill};
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    typedef struct {
        logic [16:0] vec;
        logic        rdy;
        logic [5:0]  op;
        bit          done;
        string       tag;
    } cyc_t;

    cyc_t        plan[$];
    logic [31:0] m_cycles;
    logic [31:0] m_instr;

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rrdy();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void add(input logic [16:0] v, input logic r, input logic [5:0] o,
                                input bit d, input string t);
        cyc_t c;
        c.vec = v; c.rdy = r; c.op = o; c.done = d; c.tag = t;
        plan.push_back(c);
    endfunction

    // Expand one instruction into its expected cycles. fw = fetch wait cycles,
    // mw = data memory wait cycles. Don't-care inputs are randomised.
    function automatic void build(input logic [5:0] op, input int fw, input int mw);
        bit ok;
        ok = legal(op);
        for (int i = 0; i < fw; i++)
            add(ov(1,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0), 1'b0, rop(), 0, "fetch_wait");
        add(ov(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0,0), 1'b1, rop(), 0, "fetch");
        add(ov(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,!ok), rrdy(), op, 0, "decode");
        if (!ok) return;
        case (op)
            6'b100011: begin
                add(ov(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), rrdy(), op, 0, "lw_adr");
                for (int i = 0; i < mw; i++)
                    add(ov(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b0, rop(), 0, "lw_rd_wait");
                add(ov(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b1, rop(), 0, "lw_rd");
                add(ov(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0,0), rrdy(), rop(), 1, "lw_wb");
            end
            6'b101011: begin
                add(ov(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), rrdy(), op, 0, "sw_adr");
                for (int i = 0; i < mw; i++)
                    add(ov(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b0, rop(), 0, "sw_wr_wait");
                add(ov(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b1, rop(), 1, "sw_wr");
            end
            6'b000000: begin
                add(ov(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0), rrdy(), rop(), 0, "r_exe");
                add(ov(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,0), rrdy(), rop(), 1, "r_wb");
            end
            6'b000100:
                add(ov(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,1,0), rrdy(), rop(), 1, "beq");
            6'b001000: begin
                add(ov(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), rrdy(), rop(), 0, "addi_exe");
                add(ov(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,0), rrdy(), rop(), 1, "addi_wb");
            end
            default:
                add(ov(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0), rrdy(), rop(), 1, "jump");
        endcase
    endfunction

    // Replay up to 'limit' planned cycles; called just after a rising edge
    // (or mid-cycle after reset release). Sampling is 3 ns after driving.
    task automatic run_plan(input int limit);
        int n;
        n = (limit < plan.size()) ? limit : plan.size();
        for (int i = 0; i < n; i++) begin
            Op       = plan[i].op;
            MemReady = plan[i].rdy;
            #3;
            check(plan[i].tag, {15'd0, w_obs}, {15'd0, plan[i].vec});
`ifdef PERF_CNT_EN
            check("cycle_cnt", CycleCnt, m_cycles);
            check("instr_cnt", InstrCnt, m_instr);
`endif
            @(posedge CLK);
            #1;
            m_cycles = m_cycles + 32'd1;
            if (plan[i].done) m_instr = m_instr + 32'd1;
        end
        plan.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, {15'd0, w_obs}, 32'd0);
`ifdef PERF_CNT_EN
        check({tag, "_cyc"}, CycleCnt, 32'd0);
        check({tag, "_ins"}, InstrCnt, 32'd0);
`endif
    endtask

    logic [5:0] ops[6];

    initial begin
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
        m_cycles = '0;
        m_instr  = '0;

        // Reset held low 15 ns, LW with memory always ready
        RST      = 1'b0;
        Op       = 6'b100011;
        MemReady = 1'b1;
        #12;
        check_reset_state("reset");
        #3;
        RST = 1'b1;
        build(6'b100011, 0, 0);
        run_plan(1000);

        // SW with three data-memory wait cycles
        build(6'b101011, 0, 3);
        run_plan(1000);

        // R-type then BEQ
        build(6'b000000, 0, 0);
        run_plan(1000);
        build(6'b000100, 0, 0);
        run_plan(1000);

        // Two fetch wait cycles, then ADDI and J
        build(6'b001000, 2, 0);
        run_plan(1000);
        build(6'b000010, 0, 0);
        run_plan(1000);

        // Unsupported opcode
        build(6'b111111, 0, 0);
        run_plan(1000);

        // Reset pulsed in the middle of a waiting LW read
        build(6'b100011, 0, 3);
        run_plan(4);
        RST = 1'b0;
        #1;
        check_reset_state("arst_async");
        @(posedge CLK);
        #1;
        check_reset_state("arst_held");
        #3;
        RST      = 1'b1;
        m_cycles = '0;
        m_instr  = '0;
        build(6'b000100, 1, 0);
        run_plan(1000);

        // Random instruction stream with random wait states
        for (int k = 0; k < 150; k++) begin
            logic [5:0] op;
            int sel;
            sel = $urandom_range(0, 7);
            op  = (sel < 6) ? ops[sel] : rop();
            build(op, $urandom_range(0, 2), $urandom_range(0, 3));
            run_plan(1000);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS-subset datapath; instantiated inside topp next to the datapath.
- Decodes the 6-bit opcode latched in the instruction register and sequences fetch, decode, address, memory, execute and writeback cycles.
- Drives every datapath mux select and write enable.
- Adds a memory-ready handshake so instruction/data memory may take multiple cycles.

Parameters:
CNT_W, 32, width of the performance counters (used only with the optional feature)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
Op  input  6  opcode field from instruction register
MemReady  input  1  memory completed current read/write this cycle
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IorD  output  1  memory address select: 0=PC, 1=ALUOut
IRWrite  output  1  instruction register load
RegDst  output  1  write-register select: 0=rt, 1=rd
MemtoReg  output  1  writeback data select: 0=ALUOut, 1=MDR
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0=PC, 1=A register
ALUSrcB  output  2  00=B, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm<<2
ALUOp  output  2  00=add, 01=sub, 10=use funct
PCSrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
PCWrite  output  1  unconditional PC load
Branch  output  1  PC load qualified by datapath Zero
IllegalOp  output  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset: while RST=0, state=FETCH and all outputs forced to 0 (asynchronous). Outputs are combinational decodes of state, plus MemReady where noted.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCWrite=MemReady. Stay while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state:
  - LW/SW -> MEMADR
  - R -> EXECUTE
  - BEQ -> BRANCH
  - ADDI -> ADDIEXEC
  - J -> JUMP
  - any other opcode -> FETCH with IllegalOp=1 in this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until MemReady, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Strobe held continuously while MemReady=0. On MemReady go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next FETCH.
- Latency with MemReady tied high:
  - LW 5 cycles
  - SW, R, ADDI 4 cycles
  - BEQ, J 3 cycles
  - each wait cycle adds 1
- Op is sampled only in DECODE and MEMADR; changes in other states are ignored.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction: immediate return to FETCH, outputs 0, no partial writes after the reset edge.
- State encoding is 4 bits; unused codes recover to FETCH on the next clock.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined: adds outputs CycleCnt[CNT_W-1:0] and InstrCnt[CNT_W-1:0], both reset to 0.
  - CycleCnt increments every clock.
  - InstrCnt increments on each transition into FETCH from a completing state (MEMWB, MEMWR+MemReady, ALUWB, BRANCH, ADDIWB, JUMP).
  - Illegal-opcode returns do not count.
  - Both wrap modulo 2^CNT_W.
- Undefined: ports and counters absent; no other behaviour changes.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - state enum typedef mc_state_t
  - ALUOp, ALUSrcB and PCSrc encodings
- Datapath and ALU decoder import the same package.
- One natural sub-module: mc_perf_counters, instantiated only under PERF_CNT_EN.

Test Plan:
- Reset held low 15 ns then released, Op=100011, MemReady=1 -> every output 0 during reset; state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 and MemtoReg=1 only in cycle 5.
- SW (Op=101011), MemReady low 3 cycles in MEMWR -> MemWrite=1, IorD=1 for 4 consecutive cycles; return to FETCH after MemReady=1; RegWrite never asserted.
- R-type (Op=000000) then BEQ (Op=000100), MemReady=1 -> ALUOp=10 in EXECUTE, RegDst=1 in ALUWB; BEQ completes in 3 cycles with ALUOp=01, PCSrc=01, Branch=1 in cycle 3.
- FETCH with MemReady=0 for 2 cycles -> IRWrite and PCWrite stay 0 until the MemReady cycle, then both 1 for exactly one cycle.
- Op=111111 at DECODE -> IllegalOp=1 for one cycle, next state FETCH, no write enables asserted; with PERF_CNT_EN, InstrCnt unchanged.
- Reset pulsed low during MEMRD of LW -> outputs 0 asynchronously; after release, FETCH restarts; with PERF_CNT_EN, CycleCnt=0 and InstrCnt=0.
